// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, read back through a registered port for the decrypt core.
module aes_key_schedule_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_ready,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sboxLookup(input logic [7:0] b);
        return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rconFor(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rkFile_q [0:10];
    logic [127:0] rkData_q, rkData_d;

    logic         wrEn;
    logic [3:0]   wrIdx;
    logic [127:0] wrData;
    logic [3:0]   prevIdx;
    logic [127:0] prevKey;
    logic [31:0]  w0, w1, w2, w3, rotW, subW, tWord;
    logic [31:0]  n0, n1, n2, n3;

    always_comb begin
        prevIdx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
        prevKey = rkFile_q[prevIdx];
        {w0, w1, w2, w3} = prevKey;
        rotW  = {w3[23:0], w3[31:24]};
        subW  = {sboxLookup(rotW[31:24]), sboxLookup(rotW[23:16]),
                 sboxLookup(rotW[15:8]),  sboxLookup(rotW[7:0])};
        tWord = subW ^ {rconFor(round_q), 24'h0};
        n0 = w0 ^ tWord;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    // A key offered while expanding is dropped, not queued.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        wrEn    = 1'b0;
        wrIdx   = 4'd0;
        wrData  = key;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    state_d = EXPAND;
                    round_d = 4'd1;
                    wrEn    = 1'b1;
                end
            end
            EXPAND: begin
                wrEn   = 1'b1;
                wrIdx  = round_q;
                wrData = {n0, n1, n2, n3};
                if (round_q == 4'd10) begin
                    state_d = DONE;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rkData_d = '0;
        if (rk_addr < 4'd11) begin
            rkData_d = rkFile_q[rk_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            round_q  <= 4'd0;
            rkData_q <= '0;
            for (int i = 0; i < 11; i++) begin
                rkFile_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            rkData_q <= rkData_d;
            if (wrEn) begin
                rkFile_q[wrIdx] <= wrData;
            end
        end
    end

    assign busy       = (state_q == EXPAND);
    assign keys_ready = (state_q == DONE);
    assign key_ready  = ~busy;
    assign rk_data    = rkData_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 App. A and C.1 keys.
module tb_aes_key_schedule_seq;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK3    = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] A_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C    = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         busy;
    logic         keys_ready;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int cmpCount = 0;
    int errCount = 0;
    logic [127:0] cExp [0:15];
    logic [127:0] rd;
    int busyCount;
    int firstReady;
    int lowCount;

    aes_key_schedule_seq dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] k, input logic r);
        key_valid = v;
        key       = k;
        rst       = r;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic readKey(input logic [3:0] a, output logic [127:0] d);
        rk_addr = a;
        tick();
        d = rk_data;
    endtask

    initial begin
        cExp[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        cExp[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        cExp[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        cExp[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        cExp[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        cExp[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        cExp[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        cExp[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        cExp[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        cExp[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        cExp[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 11; i < 16; i++) cExp[i] = '0;

        rk_addr = 4'd0;
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        tick();
        checkOutput("rst_key_ready",  128'(key_ready),  128'd1);
        checkOutput("rst_busy",       128'(busy),       128'd0);
        checkOutput("rst_keys_ready", 128'(keys_ready), 128'd0);
        checkOutput("rst_rk_data",    rk_data,          128'd0);
        applyStimulus(1'b0, '0, 1'b0);
        tick();

        $display("[TB] App. A key: timing and round keys");
        applyStimulus(1'b1, KEY_A, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        busyCount  = 0;
        firstReady = -1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            if (busy) busyCount++;
            if (keys_ready && firstReady < 0) firstReady = k;
        end
        checkOutput("a_busy_cycles",  128'(busyCount),  128'd10);
        checkOutput("a_first_ready",  128'(firstReady), 128'd10);
        checkOutput("a_key_ready",    128'(key_ready),  128'd1);
        readKey(4'd0, rd);  checkOutput("a_rk0",  rd, KEY_A);
        readKey(4'd1, rd);  checkOutput("a_rk1",  rd, A_RK1);
        readKey(4'd3, rd);  checkOutput("a_rk3",  rd, A_RK3);
        readKey(4'd10, rd); checkOutput("a_rk10", rd, A_RK10);

        $display("[TB] Reload C.1 key in DONE, ignored key_valid, read collision");
        rk_addr = 4'd3;
        applyStimulus(1'b1, KEY_C, 1'b0);
        tick();
        checkOutput("c_keys_ready_fall", 128'(keys_ready), 128'd0);
        checkOutput("c_busy_after_acc",  128'(busy),       128'd1);
        applyStimulus(1'b1, KEY_A, 1'b0);
        tick();
        applyStimulus(1'b0, KEY_A, 1'b0);
        tick();
        applyStimulus(1'b1, KEY_A, 1'b0);
        tick();
        checkOutput("c_collision_old", rk_data, A_RK3);
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        checkOutput("c_collision_new", rk_data, cExp[3]);
        applyStimulus(1'b1, KEY_A, 1'b0);
        repeat (5) tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        checkOutput("c_keys_ready", 128'(keys_ready), 128'd1);
        checkOutput("c_busy_done",  128'(busy),       128'd0);

        rk_addr = 4'd0;
        tick();
        for (int i = 0; i < 16; i++) begin
            rk_addr = 4'(i + 1);
            #1;
            checkOutput($sformatf("c_sweep_%0d", i), rk_data, cExp[i]);
            tick();
        end

        $display("[TB] Held key_valid: back-to-back accept");
        applyStimulus(1'b1, KEY_A, 1'b0);
        tick();
        repeat (10) tick();
        checkOutput("h_keys_ready_t10", 128'(keys_ready), 128'd1);
        checkOutput("h_key_ready_t10",  128'(key_ready),  128'd1);
        tick();
        checkOutput("h_busy_t11",       128'(busy),       128'd1);
        checkOutput("h_keys_ready_t11", 128'(keys_ready), 128'd0);
        lowCount = 1;
        repeat (9) begin
            tick();
            if (!keys_ready) lowCount++;
        end
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        checkOutput("h_low_cycles",     128'(lowCount),   128'd10);
        checkOutput("h_keys_ready_t21", 128'(keys_ready), 128'd1);
        readKey(4'd10, rd); checkOutput("h_rk10", rd, A_RK10);

        $display("[TB] Reset mid-expansion and reset with key_valid");
        rk_addr = 4'd0;
        applyStimulus(1'b1, KEY_C, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        repeat (4) tick();
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("r_busy",       128'(busy),       128'd0);
        checkOutput("r_keys_ready", 128'(keys_ready), 128'd0);
        checkOutput("r_rk_data",    rk_data,          128'd0);
        checkOutput("r_key_ready",  128'(key_ready),  128'd1);
        applyStimulus(1'b1, KEY_C, 1'b1);
        tick();
        checkOutput("r_busy_rst_valid", 128'(busy), 128'd0);
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        checkOutput("r_no_accept_busy", 128'(busy),    128'd0);
        checkOutput("r_rk0_cleared",    rk_data,       128'd0);

        $display("[TB] Fresh App. A load after reset");
        applyStimulus(1'b1, KEY_A, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        repeat (10) tick();
        checkOutput("f_keys_ready", 128'(keys_ready), 128'd1);
        readKey(4'd10, rd); checkOutput("f_rk10", rd, A_RK10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
